// File: rtl/key_conditioner.sv
// key_conditioner: synchronizes and debounces active-low pushbuttons, emits press/release strobes,
// and owns the row/col/blk view-mode register advanced by the view key.
module key_conditioner #(
    parameter int NUM_KEYS = 4,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int VIEW_KEY = 3,
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [NUM_KEYS-1:0] key_n,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic [1:0]          view_mode
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    logic [NUM_KEYS-1:0] sync1_q, sync2_q, s;
    logic [NUM_KEYS-1:0] level_q, level_d, press_q, press_d, release_q, release_d;
    logic [CNT_W-1:0]    cnt_q [NUM_KEYS];
    logic [CNT_W-1:0]    cnt_d [NUM_KEYS];
    logic [1:0]          view_q, view_d;
    // synchronizer flops hold the raw active-low key, so reset value 1 means released
    assign s = ~sync2_q;
    always_comb begin
        level_d   = level_q;
        press_d   = '0;
        release_d = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            cnt_d[i] = '0;
            if (s[i] != level_q[i]) begin
                if (cnt_q[i] == LAST) begin
                    level_d[i]   = s[i];
                    press_d[i]   = s[i];
                    release_d[i] = ~s[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
        view_d = press_q[VIEW_KEY] ? (view_q == 2'd2 ? 2'd0 : view_q + 2'd1) : view_q;
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q   <= '1;
            sync2_q   <= '1;
            level_q   <= '0;
            press_q   <= '0;
            release_q <= '0;
            view_q    <= '0;
            for (int i = 0; i < NUM_KEYS; i++) cnt_q[i] <= '0;
        end else begin
            sync1_q   <= key_n;
            sync2_q   <= sync1_q;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            view_q    <= view_d;
            for (int i = 0; i < NUM_KEYS; i++) cnt_q[i] <= cnt_d[i];
        end
    end
    assign key_level   = level_q;
    assign key_press   = press_q;
    assign key_release = release_q;
    assign view_mode   = view_q;
endmodule

// File: tb/tb_key_conditioner.sv
// tb_key_conditioner: directed plus random stimulus against a debounce reference model.
module tb_key_conditioner;
    localparam int D = 4;
    logic       clock = 0;
    logic       reset = 1;
    logic [3:0] key_n = 4'hF;
    logic [3:0] key_level, key_press, key_release;
    logic [1:0] view_mode;
    int checks = 0;
    int errors = 0;
    logic [3:0] m_old, m_new, m_lvl, m_press, m_rel;
    int m_run [4];
    int m_views;

    key_conditioner #(.NUM_KEYS(4), .DEBOUNCE_CYCLES(D), .VIEW_KEY(3)) dut (
        .clock(clock), .reset(reset), .key_n(key_n), .key_level(key_level),
        .key_press(key_press), .key_release(key_release), .view_mode(view_mode)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_old = 4'hF; m_new = 4'hF; m_lvl = 0; m_press = 0; m_rel = 0; m_views = 0;
        for (int i = 0; i < 4; i++) m_run[i] = 0;
    endtask

    // A key is accepted once its synced value has disagreed with the level for D straight cycles.
    task automatic model_step(input logic [3:0] kn);
        logic [3:0] s;
        s = ~m_old;
        if (m_press[3]) m_views++;
        m_press = 0; m_rel = 0;
        for (int i = 0; i < 4; i++) begin
            if (s[i] != m_lvl[i]) begin
                m_run[i]++;
                if (m_run[i] == D) begin
                    m_lvl[i] = s[i]; m_press[i] = s[i]; m_rel[i] = ~s[i]; m_run[i] = 0;
                end
            end else m_run[i] = 0;
        end
        m_old = m_new; m_new = kn;
    endtask

    task automatic check_all();
        chk("level", key_level, m_lvl);
        chk("press", key_press, m_press);
        chk("release", key_release, m_rel);
        chk("view", view_mode, m_views % 3);
        chk("press_and_release", key_press & key_release, 0);
    endtask

    task automatic tick(input logic [3:0] kn);
        key_n = kn;
        @(posedge clock);
        if (reset) model_reset(); else model_step(kn);
        #1;
        check_all();
    endtask

    initial begin
        int fp1, fp2, np, nr, rises;
        logic [3:0] kn;
        model_reset();
        // reset held while keys toggle
        for (int i = 0; i < 6; i++) tick(4'(i * 5));
        chk("reset_level", key_level, 0);
        chk("reset_view", view_mode, 0);
        reset = 0;
        for (int i = 0; i < 20; i++) tick(4'hF);
        chk("idle_level", key_level, 0);
        // single press on key 1: edge numbering starts at the first sampling edge
        fp1 = -1; np = 0; nr = 0;
        for (int e = 1; e <= 20; e++) begin
            tick(4'hD);
            if (key_press[1]) begin np++; if (fp1 < 0) fp1 = e; end
            if (key_release[1]) nr++;
        end
        chk("press1_edge", fp1, 6);
        chk("press1_count", np, 1);
        chk("release1_count", nr, 0);
        for (int i = 0; i < 10; i++) tick(4'hF);
        // short glitches on key 0 never accepted
        rises = 0;
        for (int r = 0; r < 5; r++) begin
            for (int i = 0; i < D - 1; i++) begin tick(4'hE); rises += int'(key_press[0]); end
            for (int i = 0; i < 4; i++) begin tick(4'hF); rises += int'(key_press[0]); end
        end
        chk("glitch_presses", rises, 0);
        chk("glitch_level", key_level[0], 0);
        // view key: three clean press/release cycles
        np = 0; nr = 0;
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 8; i++) begin tick(4'h7); np += int'(key_press[3]); nr += int'(key_release[3]); end
            for (int i = 0; i < 8; i++) begin tick(4'hF); np += int'(key_press[3]); nr += int'(key_release[3]); end
            chk("view_step", view_mode, (r + 1) % 3);
        end
        chk("view_presses", np, 3);
        chk("view_releases", nr, 3);
        // simultaneous presses on keys 1 and 2
        fp1 = -1; fp2 = -1;
        for (int e = 1; e <= 12; e++) begin
            tick(4'h9);
            if (key_press[1] && fp1 < 0) fp1 = e;
            if (key_press[2] && fp2 < 0) fp2 = e;
        end
        chk("simul_press1", fp1, 6);
        chk("simul_press2", fp2, 6);
        for (int i = 0; i < 10; i++) tick(4'hF);
        // reset interrupts a debounce in progress on key 2
        np = 0;
        for (int e = 1; e <= 4; e++) begin tick(4'hB); np += int'(key_press[2]); end
        chk("pre_reset_press", np, 0);
        reset = 1;
        #1;
        model_reset();
        check_all();
        tick(4'hB);
        #2;
        reset = 0;
        fp2 = -1;
        for (int e = 1; e <= 12; e++) begin
            tick(4'hB);
            if (key_press[2] && fp2 < 0) fp2 = e;
        end
        chk("post_reset_press2", fp2, 6);
        for (int i = 0; i < 10; i++) tick(4'hF);
        // random holds of random patterns
        for (int seg = 0; seg < 150; seg++) begin
            kn = 4'($urandom_range(0, 15));
            for (int i = 0; i < int'($urandom_range(1, 7)); i++) tick(kn);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
